// File: rtl/addsub_pkg.sv
// addsub_pkg
// Shared definitions for the pipelined adder/subtractor.
//   mode_t       : 2-bit operation encoding carried on i_mode
//   mode_is_sub  : 1 when the B operand is inverted and +1 injected
//   mode_is_sat  : 1 when a signed overflow forces a saturated result
package addsub_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_SADD = 2'b10,
    MODE_SSUB = 2'b11
  } mode_t;

  // Bit 0 of the encoding selects subtraction, bit 1 selects saturation.
  function automatic logic mode_is_sub(input logic [1:0] mode);
    return (mode == MODE_SUB) || (mode == MODE_SSUB);
  endfunction

  function automatic logic mode_is_sat(input logic [1:0] mode);
    return (mode == MODE_SADD) || (mode == MODE_SSUB);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// addsub_slice
// Combinational W-bit adder slice with generate/propagate look-ahead.
// Ports:
//   a, b  : slice operands (b already conditionally inverted by the caller)
//   cin   : carry into bit 0 of the slice
//   sum   : slice sum
//   cout  : carry out of the slice MSB
//   cmsb  : carry into the slice MSB (used for signed overflow detection)
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;
  logic         acc;
  logic         run;

  // Each carry is the flat sum-of-products over all lower generate terms,
  // so no carry depends on another carry of the same slice.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    acc  = 1'b0;
    run  = 1'b1;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      acc = 1'b0;
      run = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc = acc | (run & g[j]);
        run = run & p[j];
      end
      c[i+1] = acc | (run & cin);
    end
    sum  = p ^ c[W-1:0];
    cout = c[W];
    cmsb = c[W-1];
  end

endmodule

// File: rtl/pipe_addsub.sv
// pipe_addsub
// Pipelined add/subtract unit with optional signed saturation. The sum is
// split into STAGES slices; slice k is computed in stage k and its carry is
// registered into stage k+1. Unconsumed operand slices ride down the pipe
// shifted so the next slice always sits in the low bits; finished result
// slices accumulate in a per-stage result register.
// Ports:
//   i_clk, i_rst_n     : clock (rising edge), asynchronous active-low reset
//   i_valid / o_ready  : operand handshake, transfer when both are 1
//   i_A, i_B, i_mode   : operands and operation (see addsub_pkg::mode_t)
//   o_valid / i_ready  : result handshake, transfer when both are 1
//   S                  : result (saturated in SADD/SSUB on overflow)
//   overflow, carry    : raw signed overflow, carry out of MSB
//   zero, negative     : flags of the final S
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A stalled result (o_valid=1, i_ready=0) freezes every stage, so
// o_ready = ~o_valid | i_ready and outputs stay stable during the stall.
module pipe_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic [1:0]       i_mode,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] S,
  output logic             overflow,
  output logic             carry,
  output logic             zero,
  output logic             negative
);

  generate
    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipe_addsub: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end
  endgenerate

  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;
  localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] MAX_POS = ~MIN_NEG;

  // Stage registers
  logic             v_q   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] r_q   [STAGES];
  logic             c_q   [STAGES];
  logic             ov_q  [STAGES];
  logic             sat_q [STAGES];
  logic             sgn_q [STAGES];

  // Stage inputs (stage 0 from ports, stage k from register k-1)
  logic             v_in   [STAGES];
  logic [WIDTH-1:0] a_in   [STAGES];
  logic [WIDTH-1:0] b_in   [STAGES];
  logic [WIDTH-1:0] r_in   [STAGES];
  logic             c_in   [STAGES];
  logic             sat_in [STAGES];
  logic             sgn_in [STAGES];
  logic [WIDTH-1:0] r_nx   [STAGES];

  // Slice outputs
  logic [SW-1:0]    sum_w  [STAGES];
  logic             cout_w [STAGES];
  logic             cmsb_w [STAGES];

  logic             sub;
  logic             advance;
  logic [WIDTH-1:0] s_fin;

  assign sub     = mode_is_sub(i_mode);
  assign advance = o_ready;

  always_comb begin
    v_in[0]   = i_valid;
    a_in[0]   = i_A;
    b_in[0]   = i_B ^ {WIDTH{sub}};
    r_in[0]   = '0;
    c_in[0]   = sub;
    sat_in[0] = mode_is_sat(i_mode);
    sgn_in[0] = i_A[WIDTH-1];
    for (int k = 1; k < STAGES; k++) begin
      v_in[k]   = v_q[k-1];
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      r_in[k]   = r_q[k-1];
      c_in[k]   = c_q[k-1];
      sat_in[k] = sat_q[k-1];
      sgn_in[k] = sgn_q[k-1];
    end
    // Slice k of r_in is still zero, so OR-ing in the new slice is exact.
    for (int k = 0; k < STAGES; k++) begin
      r_nx[k] = r_in[k] | (WIDTH'(sum_w[k]) << (k * SW));
    end
  end

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      addsub_slice #(.W(SW)) u_slice (
        .a    (a_in[k][SW-1:0]),
        .b    (b_in[k][SW-1:0]),
        .cin  (c_in[k]),
        .sum  (sum_w[k]),
        .cout (cout_w[k]),
        .cmsb (cmsb_w[k])
      );
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        r_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        ov_q[k]  <= 1'b0;
        sat_q[k] <= 1'b0;
        sgn_q[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= v_in[k];
        a_q[k]   <= a_in[k] >> SW;
        b_q[k]   <= b_in[k] >> SW;
        r_q[k]   <= r_nx[k];
        c_q[k]   <= cout_w[k];
        // Only the last slice's value survives; earlier ones are overwritten.
        ov_q[k]  <= cout_w[k] ^ cmsb_w[k];
        sat_q[k] <= sat_in[k];
        sgn_q[k] <= sgn_in[k];
      end
    end
  end

  // Final stage: saturation and flags. Outputs read zero while no result
  // is present, which also gives the all-zero reset view.
  assign s_fin    = (sat_q[L] && ov_q[L]) ? (sgn_q[L] ? MIN_NEG : MAX_POS) : r_q[L];
  assign o_valid  = v_q[L];
  assign o_ready  = ~o_valid | i_ready;
  assign S        = o_valid ? s_fin : '0;
  assign overflow = o_valid & ov_q[L];
  assign carry    = o_valid & c_q[L];
  assign zero     = o_valid & (s_fin == '0);
  assign negative = o_valid & s_fin[WIDTH-1];

endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub
// Directed and randomised checks of pipe_addsub (WIDTH=32, STAGES=4).
// Results are compared in order against an expected queue as they are
// consumed; latency, stall, and reset behaviour are checked inline.
module tb_pipe_addsub;
  import addsub_pkg::*;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic             i_clk   = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_ready = 1'b1;
  logic [WIDTH-1:0] i_A     = '0;
  logic [WIDTH-1:0] i_B     = '0;
  logic [1:0]       i_mode  = 2'b00;
  logic             o_ready;
  logic             o_valid;
  logic [WIDTH-1:0] S;
  logic             overflow;
  logic             carry;
  logic             zero;
  logic             negative;

  logic [35:0] obs;
  logic [35:0] held;
  logic [35:0] exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  assign obs = {S, overflow, carry, zero, negative};

  pipe_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_A      (i_A),
    .i_B      (i_B),
    .i_mode   (i_mode),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .S        (S),
    .overflow (overflow),
    .carry    (carry),
    .zero     (zero),
    .negative (negative)
  );

  // clock
  always #5 i_clk = ~i_clk;

  function automatic logic [35:0] pk(input logic [31:0] s, input logic ov,
                                     input logic c, input logic z, input logic n);
    return {s, ov, c, z, n};
  endfunction

  // Reference: 33-bit add, overflow from operand/result signs.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] m);
    logic        sb;
    logic [31:0] bb;
    logic [32:0] full;
    logic [31:0] s;
    logic        ov;
    sb   = m[0];
    bb   = sb ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {32'd0, sb};
    s    = full[31:0];
    ov   = (a[31] == bb[31]) && (s[31] != a[31]);
    if (m[1] && ov) s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return {s, ov, full[32], (s == 32'd0), s[31]};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] want);
    n_vec++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // scoreboard: every consumed result must match the queue head
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", {35'd0, o_valid}, 36'd0);
      else chk("result", obs, exp_q.pop_front());
    end
  end

  // driver: present one operand set, wait for acceptance, push expectation
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] m, input logic [35:0] want);
    int t;
    t       = 0;
    i_valid = 1'b1;
    i_A     = a;
    i_B     = b;
    i_mode  = m;
    @(negedge i_clk);
    while (!o_ready && t < 64) begin
      t++;
      @(negedge i_clk);
    end
    if (!o_ready) chk("send_timeout", {35'd0, o_ready}, 36'd1);
    else exp_q.push_back(want);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_A     = $urandom;
    i_B     = $urandom;
    i_mode  = 2'($urandom_range(0, 3));
  endtask

  task automatic drain();
    int t;
    t       = 0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    while (exp_q.size() != 0 && t < 64) begin
      @(posedge i_clk);
      t++;
    end
    repeat (2) @(posedge i_clk);
    #1;
    chk("drain_empty", 36'(exp_q.size()), 36'd0);
  endtask

  initial begin
    int idx;

    // reset state
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_outputs", obs, 36'd0);
    chk("reset_ready_valid", {34'd0, o_ready, o_valid}, {34'd0, 1'b1, 1'b0});
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // ADD overflow with exact latency check
    i_valid = 1'b1;
    i_A     = 32'h7FFF_FFFF;
    i_B     = 32'h0000_0001;
    i_mode  = MODE_ADD;
    @(negedge i_clk);
    chk("accept_ready", {35'd0, o_ready}, 36'd1);
    exp_q.push_back(pk(32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1));
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge i_clk);
      chk("latency_early", {35'd0, o_valid}, 36'd0);
    end
    @(negedge i_clk);
    chk("latency_on_time", {35'd0, o_valid}, 36'd1);
    drain();

    // directed corner vectors, back to back
    send(32'hFFFF_FFFF, 32'h0000_0001, MODE_ADD,  pk(32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0));
    send(32'h0000_0005, 32'h0000_0005, MODE_SUB,  pk(32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0));
    send(32'h7FFF_FFFF, 32'h0000_0001, MODE_SADD, pk(32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0));
    send(32'h8000_0000, 32'h0000_0001, MODE_SSUB, pk(32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1));
    send(32'h0000_0000, 32'h0000_0001, MODE_SUB,  pk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1));
    send(32'h8000_0000, 32'h8000_0000, MODE_SADD, pk(32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1));
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF, MODE_SSUB, pk(32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0));
    send(32'h0000_0010, 32'hFFFF_FFF0, MODE_SADD, pk(32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0));
    send(32'h00FF_FFFF, 32'h0000_0001, MODE_ADD,  pk(32'h0100_0000, 1'b0, 1'b0, 1'b0, 1'b0));
    drain();

    // 8 back-to-back inputs, consumer stalls for 3 cycles mid-stream
    idx  = 1;
    held = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      i_ready = !(cyc >= 5 && cyc <= 7);
      if (idx <= 8) begin
        i_valid = 1'b1;
        i_A     = 32'(idx);
        i_B     = 32'(32'h100 * idx);
        i_mode  = MODE_ADD;
      end else begin
        i_valid = 1'b0;
      end
      @(negedge i_clk);
      if (cyc == 5) held = obs;
      if (cyc >= 5 && cyc <= 7) begin
        chk("stall_valid", {35'd0, o_valid}, 36'd1);
        chk("stall_ready_low", {35'd0, o_ready}, 36'd0);
      end
      if (cyc == 6 || cyc == 7) chk("stall_hold", obs, held);
      if (i_valid && o_ready) begin
        exp_q.push_back(pk(32'(32'h101 * idx), 1'b0, 1'b0, 1'b0, 1'b0));
        idx++;
      end
      @(posedge i_clk);
      #1;
    end
    chk("stall_all_accepted", 36'(idx), 36'd9);
    drain();

    // reset with three operations in flight
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1;
      i_A     = 32'(k + 10);
      i_B     = 32'(k);
      i_mode  = MODE_ADD;
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    @(posedge i_clk);
    #1;
    chk("pre_reset_valid", {35'd0, o_valid}, 36'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("reset_kills_valid", {34'd0, o_valid, o_ready}, {34'd0, 1'b0, 1'b1});
    chk("reset_clears_result", obs, 36'd0);
    exp_q.delete();
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_A     = 32'h0000_00FF;
    i_B     = 32'h0000_0001;
    i_mode  = MODE_ADD;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    exp_q.push_back(pk(32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge i_clk);
      chk("post_reset_no_stale", {35'd0, o_valid}, 36'd0);
    end
    @(negedge i_clk);
    chk("post_reset_latency", {35'd0, o_valid}, 36'd1);
    drain();

    // random modes/operands with random handshakes
    for (int cyc = 0; cyc < 3000; cyc++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      i_A     = pick_operand();
      i_B     = pick_operand();
      i_mode  = 2'($urandom_range(0, 3));
      @(negedge i_clk);
      if (i_valid && o_ready) exp_q.push_back(model(i_A, i_B, i_mode));
      @(posedge i_clk);
      #1;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
